control_unit_p: RTL and testbench

CONTROL_UNIT_P -- requirements
Module: control_unit_p

---
 rtl/cu_pkg.sv | 126 ++++++++++++
 rtl/cu_encoder.sv | 43 ++++
 rtl/control_unit_p.sv | 84 ++++++++
 tb/tb_control_unit_p.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - microword field layout, state numbers, next-address modes and microstore table (CU_LSM_EN gates LSM decode/status)
package cu_pkg;

    // Optional load/store-multiple support, resolved once here for every importer.
`ifdef CU_LSM_EN
    localparam logic LSM_EN = 1'b1;
`else
    localparam logic LSM_EN = 1'b0;
`endif

    // Microword field positions; bit 53 and bits 63:58 are always zero.
    localparam int N_HI      = 57;
    localparam int N_LO      = 55;
    localparam int INV_BIT   = 54;
    localparam int S_HI      = 52;
    localparam int S_LO      = 50;
    localparam int CR15_8_HI = 49;
    localparam int CR15_8_LO = 42;
    localparam int CR7_0_HI  = 41;
    localparam int CR7_0_LO  = 34;
    localparam int CTL_W     = 34;

    // Datapath control bit positions within CTL (FRLd at the top, MF at bit 0).
    localparam int FRLD  = 33;
    localparam int RFLD  = 32;
    localparam int IRLD  = 31;
    localparam int MARLD = 30;
    localparam int MDRLD = 29;
    localparam int RW    = 28;
    localparam int MOV   = 27;
    localparam int MF    = 0;

    localparam logic [CTL_W-1:0] C_NONE  = '0;
    localparam logic [CTL_W-1:0] C_FRLD  = 34'd1 << FRLD;
    localparam logic [CTL_W-1:0] C_RFLD  = 34'd1 << RFLD;
    localparam logic [CTL_W-1:0] C_IRLD  = 34'd1 << IRLD;
    localparam logic [CTL_W-1:0] C_MARLD = 34'd1 << MARLD;
    localparam logic [CTL_W-1:0] C_MDRLD = 34'd1 << MDRLD;
    localparam logic [CTL_W-1:0] C_RW    = 34'd1 << RW;
    localparam logic [CTL_W-1:0] C_MOV   = 34'd1 << MOV;
    localparam logic [CTL_W-1:0] C_MF    = 34'd1 << MF;

    // Next-address modes (N2-N0).
    typedef enum logic [2:0] {
        N_ENC      = 3'b000,
        N_INC      = 3'b001,
        N_CR       = 3'b010,
        N_STS_CR   = 3'b011,
        N_WAIT     = 3'b100,
        N_STS_ENC  = 3'b101,
        N_STS_CR15 = 3'b110,
        N_CR_ALT   = 3'b111
    } nmode_t;

    // Status selects (S2-S0); 101..111 read constant 0.
    typedef enum logic [2:0] {
        S_MOC     = 3'b000,
        S_COND    = 3'b001,
        S_LSM_DET = 3'b010,
        S_LSM_END = 3'b011,
        S_ONE     = 3'b100,
        S_ZERO    = 3'b111
    } smode_t;

    // Microprogram state numbers.
    localparam logic [7:0] ST_RESET     = 8'd0;
    localparam logic [7:0] ST_FETCH     = 8'd1;
    localparam logic [7:0] ST_READ      = 8'd2;
    localparam logic [7:0] ST_IRLOAD    = 8'd3;
    localparam logic [7:0] ST_DECODE    = 8'd4;
    localparam logic [7:0] ST_DP_SHIFT  = 8'd10;
    localparam logic [7:0] ST_DP_IMM    = 8'd11;
    localparam logic [7:0] ST_DP_REGSH  = 8'd14;
    localparam logic [7:0] ST_LD_OFF_I0 = 8'd16;
    localparam logic [7:0] ST_LD_PST_I0 = 8'd17;
    localparam logic [7:0] ST_LD_PRE_I0 = 8'd18;
    localparam logic [7:0] ST_ST_PRE_I0 = 8'd19;
    localparam logic [7:0] ST_ST_OFF_I0 = 8'd20;
    localparam logic [7:0] ST_LD_OFF_I1 = 8'd21;
    localparam logic [7:0] ST_LD_PST_I1 = 8'd22;
    localparam logic [7:0] ST_LD_PRE_I1 = 8'd23;
    localparam logic [7:0] ST_ST_PST_I0 = 8'd24;
    localparam logic [7:0] ST_ST_OFF_I1 = 8'd25;
    localparam logic [7:0] ST_ST_PRE_I1 = 8'd26;
    localparam logic [7:0] ST_ST_PST_I1 = 8'd27;
    localparam logic [7:0] ST_LSM_ST    = 8'd30;
    localparam logic [7:0] ST_LSM_LD    = 8'd31;
    localparam logic [7:0] ST_BRANCH    = 8'd43;
    localparam logic [7:0] ST_BRLINK    = 8'd44;

    // Pack one microword from its fields.
    function automatic logic [63:0] uword(input nmode_t n, input logic inv, input smode_t s,
                                          input logic [7:0] cr15_8, input logic [7:0] cr7_0,
                                          input logic [CTL_W-1:0] ctl);
        return {6'b0, n, inv, 1'b0, s, cr15_8, cr7_0, ctl};
    endfunction

    // 256x64 microstore; every unlisted address returns to fetch with no controls.
    function automatic logic [63:0] microstore(input logic [7:0] addr);
        logic [63:0] w;
        case (addr)
            ST_RESET:     w = uword(N_CR,      1'b0, S_MOC,     8'd0,     ST_FETCH,  C_NONE);
            ST_FETCH:     w = uword(N_INC,     1'b0, S_MOC,     8'd0,     8'd0,      C_MARLD);
            ST_READ:      w = uword(N_WAIT,    1'b0, S_MOC,     8'd0,     8'd0,      C_MOV | C_RW);
            ST_IRLOAD:    w = uword(N_INC,     1'b0, S_MOC,     8'd0,     8'd0,      C_IRLD);
            ST_DECODE:    w = uword(N_STS_ENC, 1'b0, S_COND,    8'd0,     ST_FETCH,  C_NONE);
            ST_DP_SHIFT,
            ST_DP_IMM,
            ST_DP_REGSH:  w = uword(N_CR,      1'b0, S_MOC,     8'd0,     ST_FETCH,  C_RFLD | C_FRLD);
            ST_LD_OFF_I0, ST_LD_PST_I0, ST_LD_PRE_I0,
            ST_LD_OFF_I1, ST_LD_PST_I1, ST_LD_PRE_I1:
                          w = uword(N_CR,      1'b0, S_MOC,     8'd0,     ST_FETCH,  C_MARLD | C_MDRLD);
            ST_ST_PRE_I0, ST_ST_OFF_I0, ST_ST_PST_I0,
            ST_ST_OFF_I1, ST_ST_PRE_I1, ST_ST_PST_I1:
                          w = uword(N_CR,      1'b0, S_MOC,     8'd0,     ST_FETCH,  C_MARLD | C_MOV);
            // List walk: leave on list end, otherwise keep scanning this state.
            ST_LSM_ST,
            ST_LSM_LD:    w = uword(N_STS_CR15, 1'b0, S_LSM_END, ST_FETCH, addr,     C_MARLD | C_MF);
            ST_BRANCH:    w = uword(N_CR,      1'b0, S_MOC,     8'd0,     ST_FETCH,  C_RFLD);
            ST_BRLINK:    w = uword(N_CR,      1'b0, S_MOC,     8'd0,     ST_FETCH,  C_RFLD | C_MF);
            default:      w = uword(N_CR,      1'b0, S_MOC,     8'd0,     ST_FETCH,  C_NONE);
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cu_encoder.sv
// rtl/cu_encoder.sv - combinational instruction decode to microprogram entry state (CU_LSM_EN gates LSM entry)
module cu_encoder
    import cu_pkg::*;
(
    input  logic [31:0] ir,
    output logic [7:0]  state
);

    logic i_bit, p_bit, w_bit, l_bit;
    logic ir_unused;

    assign i_bit = ir[25];
    assign p_bit = ir[24];
    assign w_bit = ir[21];
    assign l_bit = ir[20];
    assign ir_unused = ^{ir[31:28], ir[23:22], ir[19:8], ir[6:5], ir[3:0]};

    // Map the instruction class and addressing mode onto its first microstate.
    always_comb begin
        state = ST_FETCH;
        case (ir[27:25])
            3'b000: begin
                if (!ir[4])      state = ST_DP_SHIFT;
                else if (!ir[7]) state = ST_DP_REGSH;
            end
            3'b001: state = ST_DP_IMM;
            3'b010, 3'b011: begin
                case ({i_bit, l_bit})
                    2'b01:   state = !p_bit ? ST_LD_PST_I0 : (w_bit ? ST_LD_PRE_I0 : ST_LD_OFF_I0);
                    2'b00:   state = !p_bit ? ST_ST_PST_I0 : (w_bit ? ST_ST_PRE_I0 : ST_ST_OFF_I0);
                    2'b11:   state = !p_bit ? ST_LD_PST_I1 : (w_bit ? ST_LD_PRE_I1 : ST_LD_OFF_I1);
                    default: state = !p_bit ? ST_ST_PST_I1 : (w_bit ? ST_ST_PRE_I1 : ST_ST_OFF_I1);
                endcase
            end
            3'b100: begin
                if (LSM_EN) state = l_bit ? ST_LSM_LD : ST_LSM_ST;
            end
            3'b101: state = p_bit ? ST_BRLINK : ST_BRANCH;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit_p.sv
// rtl/control_unit_p.sv - microprogrammed control unit top (CU_LSM_EN enables LSM status inputs)
module control_unit_p
    import cu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IR,
    input  logic        MOC,
    input  logic        COND,
    input  logic        LSM_DETECT,
    input  logic        LSM_END,
    output logic [33:0] CTL
);

    logic [63:0] q;
    logic [7:0]  cur_state;
    logic [7:0]  inc_state;
    logic [7:0]  next_state;
    logic [7:0]  enc_state;
    logic [7:0]  cr15_8;
    logic [7:0]  cr7_0;
    logic [2:0]  smode;
    nmode_t      nmode;
    logic        inv;
    logic        status;
    logic        sts;
    logic        q_unused;

    assign nmode    = nmode_t'(q[N_HI:N_LO]);
    assign inv      = q[INV_BIT];
    assign smode    = q[S_HI:S_LO];
    assign cr15_8   = q[CR15_8_HI:CR15_8_LO];
    assign cr7_0    = q[CR7_0_HI:CR7_0_LO];
    assign CTL      = q[CTL_W-1:0];
    assign q_unused = ^{q[63:58], q[53]};

    cu_encoder u_encoder (
        .ir    (IR),
        .state (enc_state)
    );

    // Status multiplexer; LSM inputs read as 0 when the feature is built out.
    always_comb begin
        status = 1'b0;
        case (smode)
            S_MOC:     status = MOC;
            S_COND:    status = COND;
            S_LSM_DET: status = LSM_DETECT & LSM_EN;
            S_LSM_END: status = LSM_END & LSM_EN;
            S_ONE:     status = 1'b1;
            default:   status = 1'b0;
        endcase
        sts = status ^ inv;
    end

    // Next microaddress selection from the current microword.
    always_comb begin
        next_state = cr7_0;
        case (nmode)
            N_ENC:      next_state = enc_state;
            N_INC:      next_state = inc_state;
            N_CR:       next_state = cr7_0;
            N_STS_CR:   next_state = sts ? cr7_0 : inc_state;
            N_WAIT:     next_state = sts ? inc_state : cur_state;
            N_STS_ENC:  next_state = sts ? enc_state : cr7_0;
            N_STS_CR15: next_state = sts ? cr15_8 : cr7_0;
            N_CR_ALT:   next_state = cr7_0;
        endcase
    end

    // State, incrementer and control register; reset overrides any pending wait.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cur_state <= ST_RESET;
            inc_state <= 8'd1;
            q         <= microstore(ST_RESET);
        end else begin
            cur_state <= next_state;
            inc_state <= next_state + 8'd1;
            q         <= microstore(next_state);
        end
    end

endmodule

// File: tb/tb_control_unit_p.sv
// tb/tb_control_unit_p.sv - scoreboard bench for control_unit_p (expectations follow CU_LSM_EN)
module tb_control_unit_p;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IR;
    logic        MOC;
    logic        COND;
    logic        LSM_DETECT;
    logic        LSM_END;
    logic [33:0] CTL;

    control_unit_p dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IR         (IR),
        .MOC        (MOC),
        .COND       (COND),
        .LSM_DETECT (LSM_DETECT),
        .LSM_END    (LSM_END),
        .CTL        (CTL)
    );

    always #5 CLK = ~CLK;

    localparam logic [33:0] E_NONE  = 34'h0;
    localparam logic [33:0] E_MARLD = 34'h0_4000_0000;
    localparam logic [33:0] E_IRLD  = 34'h0_8000_0000;
    localparam logic [33:0] E_READ  = 34'h0_1800_0000;

`ifdef CU_LSM_EN
    localparam logic [7:0] E_LSM = 8'd30;
`else
    localparam logic [7:0] E_LSM = 8'd1;
`endif

    typedef struct {
        int          cyc;
        logic [7:0]  st;
        logic        chk;
        logic [33:0] ctl;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compare every expectation that targets the edge just taken.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (e.cyc != cyc_cnt || dut.cur_state !== e.st) begin
                n_fail++;
                $display("FAIL %s state: got %0d expected %0d (cycle %0d/%0d)",
                         e.nm, dut.cur_state, e.st, cyc_cnt, e.cyc);
            end
            if (e.chk) begin
                n_tests++;
                if (CTL !== e.ctl) begin
                    n_fail++;
                    $display("FAIL %s ctl: got %h expected %h", e.nm, CTL, e.ctl);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic [31:0] ir, input logic moc,
                        input logic cond, input logic [7:0] es, input logic chk,
                        input logic [33:0] ec, input string nm);
        exp_t e;
        RESET = rst;
        IR    = ir;
        MOC   = moc;
        COND  = cond;
        e.cyc = cyc_cnt + 1;
        e.st  = es;
        e.chk = chk;
        e.ctl = ec;
        e.nm  = nm;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Reset, fetch through decode, then check the state chosen from decode.
    task automatic decode_case(input logic [31:0] ir, input logic cond,
                               input logic [7:0] es, input string nm);
        step(1'b1, ir, 1'b1, cond, 8'd0, 1'b1, E_NONE,  {nm, "_rst"});
        step(1'b0, ir, 1'b1, cond, 8'd1, 1'b1, E_MARLD, {nm, "_s1"});
        step(1'b0, ir, 1'b1, cond, 8'd2, 1'b1, E_READ,  {nm, "_s2"});
        step(1'b0, ir, 1'b1, cond, 8'd3, 1'b1, E_IRLD,  {nm, "_s3"});
        step(1'b0, ir, 1'b1, cond, 8'd4, 1'b1, E_NONE,  {nm, "_s4"});
        step(1'b0, ir, 1'b1, cond, es,   1'b0, E_NONE,  nm);
    endtask

    function automatic logic [31:0] ir_hi(input logic [7:0] b);
        return {4'hE, b, 20'h00000};
    endfunction

    initial begin
        RESET = 1'b1; IR = 32'h0; MOC = 1'b0; COND = 1'b0;
        LSM_DETECT = 1'b0; LSM_END = 1'b0;

        // Fetch sequence and branch-with-link decode.
        decode_case(32'h0B000000, 1'b1, 8'd44, "bl_cond1");
        decode_case(32'h0B000000, 1'b0, 8'd1,  "bl_cond0");
        decode_case(32'h08000000, 1'b1, E_LSM, "lsm");
        decode_case(ir_hi(8'h45), 1'b1, 8'd17, "ls_45");
        decode_case(ir_hi(8'h5D), 1'b1, 8'd16, "ls_5d");
        decode_case(ir_hi(8'h5E), 1'b1, 8'd19, "ls_5e");
        decode_case(ir_hi(8'h65), 1'b1, 8'd22, "ls_65");
        decode_case(ir_hi(8'h7B), 1'b1, 8'd23, "ls_7b");
        decode_case(ir_hi(8'h7D), 1'b1, 8'd21, "ls_7d");
        decode_case(32'hE1D45004, 1'b1, 8'd10, "dp_e1d4");

        // Memory wait: MOC low holds state 2 for three edges.
        step(1'b1, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1, E_NONE,  "w_rst");
        step(1'b0, 32'h0, 1'b0, 1'b0, 8'd1, 1'b1, E_MARLD, "w_s1");
        step(1'b0, 32'h0, 1'b0, 1'b0, 8'd2, 1'b1, E_READ,  "w_s2");
        step(1'b0, 32'h0, 1'b0, 1'b0, 8'd2, 1'b1, E_READ,  "w_hold1");
        step(1'b0, 32'h0, 1'b0, 1'b0, 8'd2, 1'b1, E_READ,  "w_hold2");
        step(1'b0, 32'h0, 1'b0, 1'b0, 8'd2, 1'b1, E_READ,  "w_hold3");
        step(1'b0, 32'h0, 1'b1, 1'b0, 8'd3, 1'b1, E_IRLD,  "w_done");

        // Reset in the middle of the wait wins, then fetch resumes.
        step(1'b1, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1, E_NONE,  "r_rst");
        step(1'b0, 32'h0, 1'b0, 1'b0, 8'd1, 1'b1, E_MARLD, "r_s1");
        step(1'b0, 32'h0, 1'b0, 1'b0, 8'd2, 1'b1, E_READ,  "r_s2");
        step(1'b0, 32'h0, 1'b0, 1'b0, 8'd2, 1'b1, E_READ,  "r_hold");
        step(1'b1, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1, E_NONE,  "r_midwait");
        step(1'b0, 32'h0, 1'b1, 1'b0, 8'd1, 1'b1, E_MARLD, "r_f1");
        step(1'b0, 32'h0, 1'b1, 1'b0, 8'd2, 1'b1, E_READ,  "r_f2");
        step(1'b0, 32'h0, 1'b1, 1'b0, 8'd3, 1'b1, E_IRLD,  "r_f3");

        @(negedge CLK);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
